// File: rtl/uart_transmitter.sv
// 8N1 serial transmitter fed by a small byte FIFO.
// Bit timing uses a down-counter that is reloaded with CLKS_PER_BIT-1 at every bit boundary.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        uart_tx,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    // state | meaning
    // IDLE  | line high, waiting for the FIFO to hold a byte
    // START | start bit (0) on the line
    // DATA  | eight data bits, LSB first
    // STOP  | stop bit (1); at terminal count chain straight into the next byte or go idle
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_VAL  = (AW + 1)'(FIFO_DEPTH);

    logic [1:0]    state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          push;
    logic          pop;
    logic          bit_tc;
    logic          fifo_empty;

    assign tx_ready   = fifo_count < DEPTH_VAL;
    assign fifo_empty = fifo_count == '0;
    assign push       = tx_valid && tx_ready;
    assign bit_tc     = bit_cnt == '0;
    assign tx_busy    = state != IDLE;

    // Pop only from IDLE or at the last cycle of a stop bit, and never when empty.
    assign pop = !fifo_empty && ((state == IDLE) || (state == STOP && bit_tc));

    // Storage is not reset; clearing the pointers and count is enough to discard contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            uart_tx   <= 1'b1;
            tx_done   <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        bit_cnt   <= BIT_RELOAD;
                        uart_tx   <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_tc) begin
                        uart_tx   <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= '0;
                        bit_cnt   <= BIT_RELOAD;
                        state     <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (bit_tc) begin
                        bit_cnt <= BIT_RELOAD;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            uart_tx   <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                STOP: begin
                    if (bit_tc) begin
                        tx_done <= 1'b1;
                        // Chaining here leaves no idle cycle between back-to-back frames.
                        if (pop) begin
                            shift_reg <= mem[rd_ptr];
                            bit_cnt   <= BIT_RELOAD;
                            uart_tx   <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: directed and randomized frames compared cycle by cycle
// against an 8N1 line model derived from the byte value alone.
module tb_uart_transmitter;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_tx;
    logic       tx_busy;
    logic       tx_done;
    logic [3:0] fifo_count;

    logic [7:0] tx_data1  = 8'h00;
    logic       tx_valid1 = 1'b0;
    logic       tx_ready1;
    logic       uart_tx1;
    logic       tx_busy1;
    logic       tx_done1;
    logic [3:0] fifo_count1;

    int n_cmp     = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int done_cnt1 = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .uart_tx(uart_tx), .tx_busy(tx_busy), .tx_done(tx_done), .fifo_count(fifo_count)
    );

    uart_transmitter #(.CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .uart_tx(uart_tx1), .tx_busy(tx_busy1), .tx_done(tx_done1), .fifo_count(fifo_count1)
    );

    always @(posedge clk) begin
        if (tx_done === 1'b1)  done_cnt++;
        if (tx_done1 === 1'b1) done_cnt1++;
    end

    // Expected line level t cycles into the frame of byte b.
    function automatic logic line_bit(input logic [7:0] b, input int t, input int cpb);
        int k;
        k = t / cpb;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    // Called at a negedge; waits up to max_wait cycles for the start bit, then checks the whole frame.
    task automatic expect_frame(input logic [7:0] b, input int max_wait);
        int   waited   = 0;
        int   bad_t    = -1;
        logic bad_lvl  = 1'b0;
        logic bad_busy = 1'b0;
        while (uart_tx !== 1'b0 && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (uart_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_start byte=%02h: line=%b after %0d cycles, required 0", b, uart_tx, waited);
            return;
        end
        for (int t = 0; t < 10 * CPB; t++) begin
            if (bad_t < 0 && (uart_tx !== line_bit(b, t, CPB) || tx_busy !== 1'b1)) begin
                bad_t    = t;
                bad_lvl  = uart_tx;
                bad_busy = tx_busy;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bad_t >= 0) begin
            n_fail++;
            $display("FAIL frame byte=%02h cycle %0d: line=%b busy=%b, required line=%b busy=1",
                     b, bad_t, bad_lvl, bad_busy, line_bit(b, bad_t, CPB));
        end
    endtask

    task automatic test_reset;
        logic bad = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1)    begin n_fail++; $display("FAIL reset_line: got %b, required 1", uart_tx); end
        n_cmp++; if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
        n_cmp++; if (tx_done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b, required 0", tx_done); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
        n_cmp++; if (tx_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready: got %b, required 1", tx_ready); end
        tx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || fifo_count !== 4'd0 || tx_busy !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL valid_in_reset: line=%b count=%0d busy=%b seen, required idle 1/0/0", uart_tx, fifo_count, tx_busy);
        end
    endtask

    task automatic test_single;
        int d0 = done_cnt;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n_cmp++;
        if (uart_tx !== 1'b1 || fifo_count !== 4'd1) begin
            n_fail++;
            $display("FAIL no_fallthrough: line=%b count=%0d, required 1 and 1", uart_tx, fifo_count);
        end
        @(negedge clk);
        expect_frame(8'h55, 0);
        n_cmp++;
        if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle_after: busy=%b line=%b, required 0 and 1", tx_busy, uart_tx);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL single_done: %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bb [3] = '{8'h01, 8'h80, 8'hFF};
        int d0 = done_cnt;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    tx_data  = bb[i];
                    tx_valid = 1'b1;
                    @(negedge clk);
                end
                tx_valid = 1'b0;
            end
            begin
                expect_frame(bb[0], 2);
                expect_frame(bb[1], 0);
                expect_frame(bb[2], 0);
            end
        join
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done_cnt - d0 !== 3 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_done: pulses=%0d count=%0d, required 3 and 0", done_cnt - d0, fifo_count);
        end
    endtask

    task automatic test_fill;
        logic [7:0] fb [10];
        logic [7:0] refused;
        int d0 = done_cnt;
        for (int i = 0; i < 10; i++) fb[i] = 8'($urandom);
        refused = 8'($urandom);
        fork
            begin
                // Ten cycles of tx_valid: the first byte is popped, eight are buffered, the tenth is refused.
                for (int i = 0; i < 10; i++) begin
                    tx_data  = (i < 9) ? fb[i] : refused;
                    tx_valid = 1'b1;
                    @(negedge clk);
                end
                tx_valid = 1'b0;
                n_cmp++;
                if (fifo_count !== 4'd8 || tx_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_full: count=%0d ready=%b, required 8 and 0", fifo_count, tx_ready);
                end
                repeat (31) @(negedge clk);
                n_cmp++;
                if (tx_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_hold_ready: ready=%b before first pop, required 0", tx_ready);
                end
                @(negedge clk);
                n_cmp++;
                if (tx_ready !== 1'b1 || fifo_count !== 4'd7) begin
                    n_fail++;
                    $display("FAIL fill_after_pop: ready=%b count=%0d, required 1 and 7", tx_ready, fifo_count);
                end
                tx_data  = fb[9];
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                n_cmp++;
                if (tx_ready !== 1'b0 || fifo_count !== 4'd8) begin
                    n_fail++;
                    $display("FAIL fill_refill: ready=%b count=%0d, required 0 and 8", tx_ready, fifo_count);
                end
            end
            begin
                for (int i = 0; i < 10; i++) expect_frame(fb[i], (i == 0) ? 2 : 0);
            end
        join
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done_cnt - d0 !== 10 || fifo_count !== 4'd0 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_end: pulses=%0d count=%0d busy=%b, required 10, 0, 0", done_cnt - d0, fifo_count, tx_busy);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            logic [7:0] rb  [9];
            int         gap [9];
            int         n;
            int         d0;
            n  = int'($urandom_range(1, 9));
            d0 = done_cnt;
            for (int i = 0; i < 9; i++) begin
                rb[i]  = 8'($urandom);
                gap[i] = int'($urandom_range(0, 2));
            end
            // All pushes land within the first frame, so the FIFO never overflows and frames stay contiguous.
            fork
                begin
                    for (int i = 0; i < n; i++) begin
                        tx_data  = rb[i];
                        tx_valid = 1'b1;
                        @(negedge clk);
                        tx_valid = 1'b0;
                        repeat (gap[i]) @(negedge clk);
                    end
                end
                begin
                    for (int i = 0; i < n; i++) expect_frame(rb[i], (i == 0) ? 2 : 0);
                end
            join
            repeat (2) @(negedge clk);
            n_cmp++;
            if (done_cnt - d0 !== n || fifo_count !== 4'd0 || tx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL random_%0d_end: pulses=%0d count=%0d busy=%b, required %0d, 0, 0",
                         it, done_cnt - d0, fifo_count, tx_busy, n);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] q [3] = '{8'hA3, 8'h11, 8'h22};
        logic bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_data  = q[i];
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        // Frame began one negedge ago; advance to its cycle 16, the first cycle of data bit 3.
        repeat (15) @(negedge clk);
        n_cmp++;
        if (uart_tx !== line_bit(8'hA3, 16, CPB) || fifo_count !== 4'd2) begin
            n_fail++;
            $display("FAIL mid_bit3: line=%b count=%0d, required %b and 2", uart_tx, fifo_count, line_bit(8'hA3, 16, CPB));
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (uart_tx !== 1'b1 || fifo_count !== 4'd0 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_abort: line=%b count=%0d busy=%b, required 1, 0, 0", uart_tx, fifo_count, tx_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || fifo_count !== 4'd0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL mid_discard: line=%b count=%0d seen after reset, required idle", uart_tx, fifo_count);
        end
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        expect_frame(8'h3C, 1);
    endtask

    task automatic test_cpb1;
        logic [9:0] seen = '0;
        logic [9:0] want = '0;
        int d0 = done_cnt1;
        tx_data1  = 8'hA3;
        tx_valid1 = 1'b1;
        @(negedge clk);
        tx_valid1 = 1'b0;
        n_cmp++;
        if (uart_tx1 !== 1'b1 || fifo_count1 !== 4'd1) begin
            n_fail++;
            $display("FAIL cpb1_latency: line=%b count=%0d, required 1 and 1", uart_tx1, fifo_count1);
        end
        @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            seen[t] = uart_tx1;
            want[t] = line_bit(8'hA3, t, 1);
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== want) begin
            n_fail++;
            $display("FAIL cpb1_frame: line bits (t0 at right) %b, required %b", seen, want);
        end
        n_cmp++;
        if (uart_tx1 !== 1'b1 || tx_busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL cpb1_end: line=%b busy=%b after 10 cycles, required 1 and 0", uart_tx1, tx_busy1);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done_cnt1 - d0 !== 1) begin
            n_fail++;
            $display("FAIL cpb1_done: %0d pulses, required 1", done_cnt1 - d0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_fill;
        test_random;
        test_reset_midframe;
        test_cpb1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
